cpu_scoreboard: RTL and testbench
=================================

Name: cpu_scoreboard

Overview:
- Parametrised register-hazard tracker for the CPU decode stage.
- Decides whether the instruction presented by the decoder may issue.
- Tracks two kinds of pending writes:
  - fixed-latency writes (ALU, multiply, cfg), using a short aging pipeline;
  - variable-latency writes (loads, divides), using per-register outstanding-write counters, so several loads to one register may be in flight.
- Kills speculatively issued entries when the ALU stage reports a taken jump, and reports a per-cycle stall reason for the performance counters.

Parameters:
- NUM_REGS, 32, architectural registers; register 0 is never tracked.
- REG_BITS, $clog2(NUM_REGS), width of register indices.
- CNT_BITS, 2, width of each outstanding-write counter; the maximum outstanding variable-latency writes per register is 2^CNT_BITS-1.
- MAX_FIXED_LAT, 2, largest fixed latency in cycles; must be at least 1.
- LAT_BITS, $clog2(MAX_FIXED_LAT+1), width of the latency field.
- NUM_RET, 2, number of variable-latency completion ports (memory, divider).
- FLUSH_DEPTH, 2, number of most recent issue cycles that a flush kills.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- iss_valid  in  1  decoder presents an instruction
- iss_ready  out  1  instruction is consumed this cycle (issued or killed)
- iss_use_a  in  1  the instruction reads src_a
- iss_src_a  in  REG_BITS  source register A
- iss_use_b  in  1  the instruction reads src_b
- iss_src_b  in  REG_BITS  source register B
- iss_dest  in  REG_BITS  destination register; 0 means no write
- iss_latent  in  1  the destination is written by a variable-latency unit
- iss_lat  in  LAT_BITS  fixed latency, 1..MAX_FIXED_LAT; ignored when iss_latent=1
- iss_fire  out  1  the instruction issued this cycle
- ret_valid  in  NUM_RET  completion strobes, one per port
- ret_dest  in  NUM_RET*REG_BITS  completing register, one field per port
- flush  in  1  taken jump in the ALU stage
- perf_stall  out  2  registered reason: 0 OK, 1 FLUSH, 2 DATA, 3 RESOURCE
- err_underflow  out  1  sticky; a completion arrived for a register whose counter was 0

Behaviour:
- Reset (synchronous): all counters 0, fixed and flush pipelines empty, perf_stall=0, err_underflow=0, iss_ready=1, iss_fire=0.
- Hazard evaluation uses registered state only.
  - A completion in cycle t unblocks consumers from cycle t+1.
  - An issue in cycle t is visible to the hazard check from cycle t+1.
- DATA hazard: a used source s (s≠0) meets either condition below.
  - cnt[s]>0.
  - A fixed entry for s with latency L, issued c cycles ago, has c<L. A consumer issuing c cycles after the producer stalls while c<L. L=1 never stalls; L=2 stalls the next cycle only.
- RESOURCE hazard, for iss_dest≠0:
  - iss_latent=1 and cnt[dest] is at its maximum value;
  - iss_latent=0 and cnt[dest]>0 (WAW against a pending load or divide).
- Issue outputs:
  - iss_fire = iss_valid & !flush & !hazard & !reset.
  - iss_ready = flush | !hazard.
  - An instruction presented during flush is discarded (ready=1, fire=0).
- Counter update each cycle, net sum of the following:
  - +1 for a latent fire with dest≠0;
  - −1 per ret_valid port with dest≠0 and count>0;
  - −1 per killed flush entry.
  - Same-register increment and decrement in one cycle cancel.
  - Two ports completing the same register decrement it by 2.
- Underflow: a decrement of a zero counter is clamped at 0 and sets err_underflow until reset.
- Flush pipeline: FLUSH_DEPTH stages holding {valid, latent, dest} of the fires from the last FLUSH_DEPTH cycles.
  - On flush, every valid latent entry decrements its counter.
  - On flush, all fixed entries issued within FLUSH_DEPTH cycles are invalidated.
  - On flush, both pipelines are cleared.
- Fixed pipeline: MAX_FIXED_LAT-1 stages of {valid, dest, remaining}. It shifts every cycle; an entry drops when remaining reaches 0.
- perf_stall has 1-cycle latency; priority FLUSH > DATA > RESOURCE > OK. It reports OK when iss_valid=0.
- Register 0 is never counted, never blocks, and never appears in the pipelines.

Test Plan:
- Load r5 (latent) fired, then an instruction using r5 held valid → iss_ready=0 and perf_stall=2 until ret_valid[0] with dest 5; fires the cycle after the return; cnt[5] returns to 0.
- Multiply to r3 with iss_lat=2, then a consumer of r3 in the next cycle → one stall cycle, then fire. The same sequence with iss_lat=1 → no stall.
- Three loads to r7 with CNT_BITS=2 → all fire; a fourth load to r7 stalls with perf_stall=3. A fixed-latency write to r7 also stalls with perf_stall=3.
- Load r9 fired, flush asserted the next cycle with a valid instruction present → that instruction is discarded (fire=0, ready=1); cnt[9]=0; a consumer of r9 fires immediately.
- Same-cycle ret_valid[0] and ret_valid[1] both for r4 with cnt[4]=2 → cnt[4]=0. A latent fire and a return for r4 in the same cycle leave cnt unchanged.
- Return to r6 with cnt[6]=0 → err_underflow=1 and stays set; reset clears it. Reset asserted mid-load → all counters 0, iss_ready=1.

Source files
------------

// File: rtl/cpu_scoreboard.sv
// rtl/cpu_scoreboard.sv - register-hazard scoreboard deciding decode-stage issue
//
// Tracks pending register writes and tells the decoder whether the presented
// instruction may issue this cycle.
//   clock, reset      : clock and synchronous active-high reset
//   iss_valid         : decoder presents an instruction
//   iss_ready         : instruction consumed this cycle (issued or discarded)
//   iss_use_a/b       : instruction reads iss_src_a / iss_src_b
//   iss_src_a/b       : source register indices
//   iss_dest          : destination register, 0 = no write
//   iss_latent        : destination written by a variable-latency unit
//   iss_lat           : fixed latency 1..MAX_FIXED_LAT (ignored when latent)
//   iss_fire          : instruction issued this cycle
//   ret_valid         : one completion strobe per variable-latency port
//   ret_dest          : completing register, REG_BITS per port
//   flush             : taken jump, kills the last FLUSH_DEPTH issue cycles
//   perf_stall        : registered stall reason 0 OK, 1 FLUSH, 2 DATA, 3 RESOURCE
//   err_underflow     : sticky, completion seen for a register with no pending write
module cpu_scoreboard #(
    parameter int NUM_REGS      = 32,
    parameter int REG_BITS      = $clog2(NUM_REGS),
    parameter int CNT_BITS      = 2,
    parameter int MAX_FIXED_LAT = 2,
    parameter int LAT_BITS      = $clog2(MAX_FIXED_LAT + 1),
    parameter int NUM_RET       = 2,
    parameter int FLUSH_DEPTH   = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         iss_valid,
    output logic                         iss_ready,
    input  logic                         iss_use_a,
    input  logic [REG_BITS-1:0]          iss_src_a,
    input  logic                         iss_use_b,
    input  logic [REG_BITS-1:0]          iss_src_b,
    input  logic [REG_BITS-1:0]          iss_dest,
    input  logic                         iss_latent,
    input  logic [LAT_BITS-1:0]          iss_lat,
    output logic                         iss_fire,
    input  logic [NUM_RET-1:0]           ret_valid,
    input  logic [NUM_RET*REG_BITS-1:0]  ret_dest,
    input  logic                         flush,
    output logic [1:0]                   perf_stall,
    output logic                         err_underflow
);

    // A latency-1 write never blocks, so MAX_FIXED_LAT=1 needs no real stage;
    // one always-empty stage keeps the arrays legal.
    localparam int FIX_STAGES = (MAX_FIXED_LAT > 1) ? MAX_FIXED_LAT - 1 : 1;
    // Wide enough for a counter plus one increment minus every possible decrement.
    localparam int SUM_BITS = CNT_BITS + $clog2(NUM_RET + FLUSH_DEPTH + 2) + 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        STALL_OK       = 2'd0,
        STALL_FLUSH    = 2'd1,
        STALL_DATA     = 2'd2,
        STALL_RESOURCE = 2'd3
    } stall_t;

    logic [CNT_BITS-1:0] cnt      [NUM_REGS];
    logic [CNT_BITS-1:0] cnt_next [NUM_REGS];

    // Fixed-latency pipeline: stage k holds writes issued k+1 cycles ago that
    // still have cycles remaining; a valid entry always blocks its register.
    logic                fix_valid [FIX_STAGES];
    logic [REG_BITS-1:0] fix_dest  [FIX_STAGES];
    logic [LAT_BITS-1:0] fix_rem   [FIX_STAGES];

    // Flush pipeline: fires from the last FLUSH_DEPTH cycles, stage 0 newest.
    logic                fl_valid  [FLUSH_DEPTH];
    logic                fl_latent [FLUSH_DEPTH];
    logic [REG_BITS-1:0] fl_dest   [FLUSH_DEPTH];

    stall_t perf_q;
    stall_t perf_next;
    logic   err_q;
    logic   uf_now;

    logic [NUM_REGS-1:0] fix_busy;
    logic busy_a;
    logic busy_b;
    logic data_haz;
    logic res_haz;
    logic hazard;
    logic dest_nz;
    logic fire;

    always_comb begin
        fix_busy = '0;
        for (int k = 0; k < FIX_STAGES; k++) begin
            if (fix_valid[k]) begin
                fix_busy[fix_dest[k]] = 1'b1;
            end
        end
    end

    assign dest_nz  = (iss_dest != '0);
    assign busy_a   = iss_use_a && (iss_src_a != '0) &&
                      ((cnt[iss_src_a] != '0) || fix_busy[iss_src_a]);
    assign busy_b   = iss_use_b && (iss_src_b != '0) &&
                      ((cnt[iss_src_b] != '0) || fix_busy[iss_src_b]);
    assign data_haz = busy_a || busy_b;
    // Latent writes may stack up to the counter limit; a fixed write must not
    // overtake a pending variable-latency write to the same register.
    assign res_haz  = dest_nz && (iss_latent ? (cnt[iss_dest] == CNT_MAX)
                                             : (cnt[iss_dest] != '0));
    assign hazard   = data_haz || res_haz;

    assign fire      = iss_valid && !flush && !hazard && !reset;
    assign iss_fire  = fire;
    assign iss_ready = reset || flush || !hazard;

    assign perf_stall    = perf_q;
    assign err_underflow = err_q;

    always_comb begin
        perf_next = STALL_OK;
        if (iss_valid) begin
            if (flush) begin
                perf_next = STALL_FLUSH;
            end else if (data_haz) begin
                perf_next = STALL_DATA;
            end else if (res_haz) begin
                perf_next = STALL_RESOURCE;
            end
        end
    end

    // Net counter update: increment from a latent fire, decrements from every
    // completion port and every killed latent flush entry; clamp at zero.
    always_comb begin
        logic [SUM_BITS-1:0] avail;
        logic [SUM_BITS-1:0] dec;
        avail  = '0;
        dec    = '0;
        uf_now = 1'b0;
        cnt_next[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            dec = '0;
            for (int p = 0; p < NUM_RET; p++) begin
                if (ret_valid[p] && (ret_dest[p*REG_BITS +: REG_BITS] == REG_BITS'(r))) begin
                    dec = dec + SUM_BITS'(1);
                end
            end
            if (flush) begin
                for (int k = 0; k < FLUSH_DEPTH; k++) begin
                    if (fl_valid[k] && fl_latent[k] && (fl_dest[k] == REG_BITS'(r))) begin
                        dec = dec + SUM_BITS'(1);
                    end
                end
            end
            avail = SUM_BITS'(cnt[r]) +
                    SUM_BITS'(fire && iss_latent && (iss_dest == REG_BITS'(r)));
            if (dec > avail) begin
                cnt_next[r] = '0;
                uf_now      = 1'b1;
            end else begin
                cnt_next[r] = CNT_BITS'(avail - dec);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            for (int k = 0; k < FIX_STAGES; k++) begin
                fix_valid[k] <= 1'b0;
                fix_dest[k]  <= '0;
                fix_rem[k]   <= '0;
            end
            for (int k = 0; k < FLUSH_DEPTH; k++) begin
                fl_valid[k]  <= 1'b0;
                fl_latent[k] <= 1'b0;
                fl_dest[k]   <= '0;
            end
            perf_q <= STALL_OK;
            err_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_next[r];
            end
            if (uf_now) begin
                err_q <= 1'b1;
            end
            perf_q <= perf_next;

            if (flush) begin
                for (int k = 0; k < FIX_STAGES; k++) begin
                    fix_valid[k] <= 1'b0;
                end
                for (int k = 0; k < FLUSH_DEPTH; k++) begin
                    fl_valid[k] <= 1'b0;
                end
            end else begin
                // Only latency >= 2 writes ever block, so only they enter.
                fix_valid[0] <= fire && !iss_latent && dest_nz && (iss_lat > LAT_BITS'(1));
                fix_dest[0]  <= iss_dest;
                fix_rem[0]   <= iss_lat - LAT_BITS'(1);
                for (int k = 1; k < FIX_STAGES; k++) begin
                    fix_valid[k] <= fix_valid[k-1] && (fix_rem[k-1] > LAT_BITS'(1));
                    fix_dest[k]  <= fix_dest[k-1];
                    fix_rem[k]   <= fix_rem[k-1] - LAT_BITS'(1);
                end

                fl_valid[0]  <= fire && dest_nz;
                fl_latent[0] <= iss_latent;
                fl_dest[0]   <= iss_dest;
                for (int k = 1; k < FLUSH_DEPTH; k++) begin
                    fl_valid[k]  <= fl_valid[k-1];
                    fl_latent[k] <= fl_latent[k-1];
                    fl_dest[k]   <= fl_dest[k-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_scoreboard.sv
// tb/tb_cpu_scoreboard.sv - self-checking bench for cpu_scoreboard
module tb_cpu_scoreboard;

    localparam int NR   = 32;
    localparam int RB   = 5;
    localparam int FD   = 2;
    localparam int CMAX = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          iss_valid;
    logic          iss_ready;
    logic          iss_use_a;
    logic [RB-1:0] iss_src_a;
    logic          iss_use_b;
    logic [RB-1:0] iss_src_b;
    logic [RB-1:0] iss_dest;
    logic          iss_latent;
    logic [1:0]    iss_lat;
    logic          iss_fire;
    logic [1:0]    ret_valid;
    logic [2*RB-1:0] ret_dest;
    logic          flush;
    logic [1:0]    perf_stall;
    logic          err_underflow;

    cpu_scoreboard #(
        .NUM_REGS(32), .CNT_BITS(2), .MAX_FIXED_LAT(2), .NUM_RET(2), .FLUSH_DEPTH(2)
    ) dut (
        .clock(clock), .reset(reset),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_use_a(iss_use_a), .iss_src_a(iss_src_a),
        .iss_use_b(iss_use_b), .iss_src_b(iss_src_b),
        .iss_dest(iss_dest), .iss_latent(iss_latent), .iss_lat(iss_lat),
        .iss_fire(iss_fire),
        .ret_valid(ret_valid), .ret_dest(ret_dest),
        .flush(flush),
        .perf_stall(perf_stall), .err_underflow(err_underflow)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          v;
        logic          ua;
        logic [RB-1:0] sa;
        logic          ub;
        logic [RB-1:0] sb;
        logic [RB-1:0] dest;
        logic          latent;
        logic [1:0]    lat;
        logic [1:0]    rv;
        logic [RB-1:0] rd0;
        logic [RB-1:0] rd1;
        logic          fl;
        logic          efire;
        logic          eready;
        logic [1:0]    eperf;
        logic          eerr;
    } vec_t;

    vec_t tbl[$];

    // Reference model: per-register pending counts, a list of in-flight fixed
    // writes with their issue cycle, and a history of recent fires.
    typedef struct { int dest; int cyc; int lat; } fx_t;
    typedef struct { int cyc; bit latent; int dest; } hi_t;
    int  mcnt[NR];
    fx_t fq[$];
    hi_t hq[$];
    bit  merr;
    int  mperf;
    int  now;

    function automatic vec_t mk(int v, int ua, int sa, int ub, int sb, int dest, int latent,
                                int lat, int rv, int rd0, int rd1, int fl,
                                int ef, int er, int ep, int ee);
        vec_t r;
        r.v = 1'(v); r.ua = 1'(ua); r.sa = RB'(sa); r.ub = 1'(ub); r.sb = RB'(sb);
        r.dest = RB'(dest); r.latent = 1'(latent); r.lat = 2'(lat); r.rv = 2'(rv);
        r.rd0 = RB'(rd0); r.rd1 = RB'(rd1); r.fl = 1'(fl);
        r.efire = 1'(ef); r.eready = 1'(er); r.eperf = 2'(ep); r.eerr = 1'(ee);
        return r;
    endfunction

    function automatic bit m_busy(int s);
        if (s == 0) return 1'b0;
        if (mcnt[s] > 0) return 1'b1;
        foreach (fq[i]) begin
            if (fq[i].dest == s && (now - fq[i].cyc) < fq[i].lat) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        foreach (mcnt[i]) mcnt[i] = 0;
        fq.delete();
        hq.delete();
        merr  = 1'b0;
        mperf = 0;
        now   = 0;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_use_a = 0; iss_src_a = '0; iss_use_b = 0; iss_src_b = '0;
        iss_dest = '0; iss_latent = 0; iss_lat = 2'd1; ret_valid = '0; ret_dest = '0;
        flush = 0;
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input vec_t x, input bit use_tbl, input string nm);
        bit data, res, mf, mr;
        int np, n;
        int dec[NR];
        int inc[NR];
        fx_t f;
        hi_t h;
        iss_valid = x.v; iss_use_a = x.ua; iss_src_a = x.sa; iss_use_b = x.ub;
        iss_src_b = x.sb; iss_dest = x.dest; iss_latent = x.latent; iss_lat = x.lat;
        ret_valid = x.rv; ret_dest = {x.rd1, x.rd0}; flush = x.fl;
        #1;
        data = (x.ua && m_busy(int'(x.sa))) || (x.ub && m_busy(int'(x.sb)));
        res  = (x.dest != 0) && (x.latent ? (mcnt[x.dest] == CMAX) : (mcnt[x.dest] > 0));
        mf   = x.v && !x.fl && !data && !res;
        mr   = x.fl || !(data || res);
        np   = !x.v ? 0 : x.fl ? 1 : data ? 2 : res ? 3 : 0;
        check({nm, ".fire"},  32'(iss_fire),  use_tbl ? 32'(x.efire)  : 32'(mf));
        check({nm, ".ready"}, 32'(iss_ready), use_tbl ? 32'(x.eready) : 32'(mr));

        foreach (dec[i]) begin dec[i] = 0; inc[i] = 0; end
        if (x.fl) begin
            foreach (hq[i]) begin
                if ((now - hq[i].cyc) <= FD && hq[i].latent) dec[hq[i].dest]++;
            end
            hq.delete();
            fq.delete();
        end
        if (x.rv[0] && x.rd0 != 0) dec[x.rd0]++;
        if (x.rv[1] && x.rd1 != 0) dec[x.rd1]++;
        if (mf && x.dest != 0) begin
            if (x.latent) begin
                inc[x.dest]++;
            end else begin
                f.dest = int'(x.dest); f.cyc = now; f.lat = int'(x.lat);
                fq.push_back(f);
            end
            h.cyc = now; h.latent = x.latent; h.dest = int'(x.dest);
            hq.push_back(h);
        end
        for (int r = 1; r < NR; r++) begin
            n = mcnt[r] + inc[r] - dec[r];
            if (n < 0) begin
                n = 0;
                merr = 1'b1;
            end
            mcnt[r] = n;
        end
        mperf = np;
        now++;
        for (int i = hq.size() - 1; i >= 0; i--) if ((now - hq[i].cyc) > FD) hq.delete(i);
        for (int i = fq.size() - 1; i >= 0; i--) if ((now - fq[i].cyc) >= fq[i].lat) fq.delete(i);

        @(negedge clock);
        check({nm, ".perf"}, 32'(perf_stall),    use_tbl ? 32'(x.eperf) : 32'(mperf));
        check({nm, ".err"},  32'(err_underflow), use_tbl ? 32'(x.eerr)  : 32'(merr));
    endtask

    task automatic do_reset(input string nm);
        idle_inputs();
        reset = 1;
        iss_valid = 1;
        #1;
        check({nm, ".rst_fire"},  32'(iss_fire),  32'd0);
        check({nm, ".rst_ready"}, 32'(iss_ready), 32'd1);
        @(negedge clock);
        reset = 0;
        idle_inputs();
        model_reset();
        check({nm, ".rst_perf"}, 32'(perf_stall),    32'd0);
        check({nm, ".rst_err"},  32'(err_underflow), 32'd0);
    endtask

    initial begin
        vec_t x;
        int   pend[$];
        reset = 1;
        idle_inputs();
        model_reset();

        //              v ua sa ub sb  d lt lat rv rd0 rd1 fl  fire rdy perf err
        // load r5 blocks its consumer until the cycle after the return
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 5, 0, 0, 1, 0, 1, 0, 0, 0, 0,   0, 0, 2, 0));
        tbl.push_back(mk(1, 1, 5, 0, 0, 1, 0, 1, 0, 0, 0, 0,   0, 0, 2, 0));
        tbl.push_back(mk(1, 1, 5, 0, 0, 1, 0, 1, 1, 5, 0, 0,   0, 0, 2, 0));
        tbl.push_back(mk(1, 1, 5, 0, 0, 1, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        // latency-2 multiply to r3: one stall; latency 1: none
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 0, 2, 0, 0, 0, 0,   1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 3, 0, 0, 2, 0, 1, 0, 0, 0, 0,   0, 0, 2, 0));
        tbl.push_back(mk(1, 1, 3, 0, 0, 2, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 3, 2, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        // counter saturation on r7
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0,   0, 0, 3, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 0,   0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 7, 7, 0,   0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        // flush kills the previous-cycle load and discards the presented op
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 9, 0, 0, 4, 0, 1, 0, 0, 0, 1,   0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 9, 0, 0, 4, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        // dual-port return and same-cycle fire+return on r4
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 4, 4, 0,   0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 1, 4, 0, 0,   1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0));
        // underflow on r6 is sticky
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0, 0,   0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 1, 0, 1));
        // flush reaches back two issue cycles
        tbl.push_back(mk(1, 0, 0, 0, 0,10, 1, 1, 0, 0, 0, 0,   1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,   0, 1, 0, 1));
        tbl.push_back(mk(1, 1,10, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 1, 0, 1));

        @(negedge clock);
        do_reset("init");

        foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

        // reset in the middle of outstanding loads clears counters and the sticky error
        step(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1), 1'b1, "mid_ld0");
        step(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1), 1'b1, "mid_ld1");
        do_reset("mid");
        step(mk(1, 1, 5, 1, 5, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0), 1'b1, "mid_use");

        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset("rnd_rst");
            x = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            x.v      = ($urandom_range(0, 3) != 0);
            x.ua     = 1'($urandom_range(0, 1));
            x.sa     = RB'($urandom_range(0, 7));
            x.ub     = 1'($urandom_range(0, 1));
            x.sb     = RB'($urandom_range(0, 7));
            x.dest   = RB'($urandom_range(0, 7));
            x.latent = ($urandom_range(0, 2) == 0);
            x.lat    = 2'($urandom_range(1, 2));
            pend.delete();
            for (int r = 1; r < 8; r++) if (mcnt[r] > 0) pend.push_back(r);
            if ($urandom_range(0, 3) == 0) begin
                x.rv[0] = 1'b1;
                x.rd0 = (pend.size() > 0 && $urandom_range(0, 19) != 0)
                        ? RB'(pend[$urandom_range(0, pend.size() - 1)]) : RB'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 3) == 0) begin
                x.rv[1] = 1'b1;
                x.rd1 = (pend.size() > 0 && $urandom_range(0, 19) != 0)
                        ? RB'(pend[$urandom_range(0, pend.size() - 1)]) : RB'($urandom_range(0, 7));
            end
            x.fl = ($urandom_range(0, 19) == 0);
            step(x, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
